csi2_tx_pkt_formatter: RTL and testbench

- Upstream stage of the D-PHY TX global-operation block.
- Accepts CSI-2 packet requests (VC, DT, WC) plus a 32-bit payload stream.
- Builds the 4-byte packet header with a 6-bit ECC, streams the payload, appends a CRC-16 footer, and drives the HS request handshake.
- Its outputs feed the downstream block's dphy_pkten_i, dphy_pkt_i, clk_hs_en_i and d_hs_en_i ports; its d_hs_rdy_i input comes from that block's d_hs_rdy_o.

---
 rtl/csi2_tx_pkg.sv | 44 ++++
 rtl/csi2_tx_crc16_32b.sv | 26 ++
 rtl/csi2_tx_pkt_formatter.sv | 225 ++++++++++++++++++++++
 tb/tb_csi2_tx_pkt_formatter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csi2_tx_pkg.sv
// Shared types, constants and header-ECC helpers for the CSI-2 TX packet path.
// The ECC masks select which of the 24 header bits feed each of the six parity bits.
package csi2_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HS_REQ = 3'd1,
    ST_PAYLD  = 3'd2,
    ST_CRC    = 3'd3,
    ST_EXIT   = 3'd4
  } tx_state_e;

  localparam logic [5:0]  SHORT_DT_MAX = 6'h0F;
  localparam logic [15:0] CRC_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC_POLY     = 16'h8408;

  // Index i holds the header-bit mask for parity bit P<i>.
  localparam logic [5:0][23:0] ECC_MASKS = {
    24'hEFFC00,
    24'hDF03F0,
    24'hB8E38E,
    24'h749A6D,
    24'hF2555B,
    24'hF12CB7
  };

  function automatic logic [5:0] csi2_ecc(input logic [23:0] hdr);
    logic [5:0] p;
    p = 6'h00;
    for (int i = 0; i < 6; i++) begin
      p[i] = ^(hdr & ECC_MASKS[i]);
    end
    return p;
  endfunction

  function automatic logic [31:0] csi2_header(input logic [1:0]  vc,
                                              input logic [5:0]  dt,
                                              input logic [15:0] wc);
    logic [23:0] hdr;
    hdr = {wc, vc, dt};
    return {2'b00, csi2_ecc(hdr), hdr};
  endfunction

endpackage

// File: rtl/csi2_tx_crc16_32b.sv
// Combinational CRC-16 (reflected x^16+x^12+x^5+1) advance over one 32-bit beat.
// Bits are consumed LSB-first starting from byte0, so bit index order equals wire order.
module csi2_tx_crc16_32b
  import csi2_tx_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [31:0] data_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_acc;

  // Serial LFSR unrolled across all 32 data bits of the beat.
  always_comb begin
    crc_acc = crc_i;
    for (int i = 0; i < 32; i++) begin
      if (crc_acc[0] ^ data_i[i]) begin
        crc_acc = (crc_acc >> 1) ^ CRC_POLY;
      end else begin
        crc_acc = crc_acc >> 1;
      end
    end
    crc_o = crc_acc;
  end

endmodule

// File: rtl/csi2_tx_pkt_formatter.sv
// CSI-2 TX packet formatter: header with ECC, payload beats, CRC-16 footer,
// and the HS clock/data request sequencing toward the D-PHY TX stage.
module csi2_tx_pkt_formatter
  import csi2_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter bit          CLK_CONTINUOUS = 1'b0,
  parameter int unsigned EXIT_GAP       = 4,
  parameter int unsigned CLK_POST       = 8
) (
  input  logic                    core_clk,
  input  logic                    reset,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [1:0]              req_vc_i,
  input  logic [5:0]              req_dt_i,
  input  logic [15:0]             req_wc_i,
  input  logic [4*DATA_WIDTH-1:0] pld_data_i,
  input  logic                    pld_valid_i,
  output logic                    pld_ready_o,
  output logic                    dphy_pkten_o,
  output logic [4*DATA_WIDTH-1:0] dphy_pkt_o,
  output logic                    clk_hs_en_o,
  output logic                    d_hs_en_o,
  input  logic                    d_hs_rdy_i,
  output logic                    busy_o,
  output logic                    underrun_o,
  output logic                    len_err_o
);

  localparam int unsigned BUS_W      = 4 * DATA_WIDTH;
  localparam logic [3:0]  EXIT_GAP_L = 4'(EXIT_GAP);
  localparam logic [7:0]  CLK_POST_L = 8'(CLK_POST);

  tx_state_e          state_q, state_d;
  logic [1:0]         vc_q, vc_d;
  logic [5:0]         dt_q, dt_d;
  logic [15:0]        wc_q, wc_d;
  logic [13:0]        beat_cnt_q, beat_cnt_d;
  logic [3:0]         gap_q, gap_d;
  logic [7:0]         post_q, post_d;
  logic [15:0]        crc_q, crc_d;
  logic [BUS_W-1:0]   pkt_q, pkt_d;
  logic               pkten_q, pkten_d;
  logic               clk_hs_en_q, clk_hs_en_d;
  logic               d_hs_en_q, d_hs_en_d;
  logic               busy_q, busy_d;
  logic               underrun_q, underrun_d;
  logic               len_err_q, len_err_d;

  logic               req_ready_s;
  logic               req_short_s;
  logic               pkt_short_s;
  logic [BUS_W-1:0]   beat_s;
  logic [15:0]        crc_next_s;

  assign req_ready_s = (state_q == ST_IDLE) && (gap_q == 4'd0) && !reset;
  assign req_short_s = (req_dt_i <= SHORT_DT_MAX);
  assign pkt_short_s = (dt_q <= SHORT_DT_MAX);
  // A missing payload beat is substituted with zeros so the stream never stalls.
  assign beat_s      = pld_valid_i ? pld_data_i : {BUS_W{1'b0}};

  assign req_ready_o = req_ready_s;
  assign pld_ready_o = (state_q == ST_PAYLD);

  csi2_tx_crc16_32b u_crc (
    .crc_i  (crc_q),
    .data_i (beat_s),
    .crc_o  (crc_next_s)
  );

  // Next-state and next-output computation for the packet sequencer.
  always_comb begin
    state_d     = state_q;
    vc_d        = vc_q;
    dt_d        = dt_q;
    wc_d        = wc_q;
    beat_cnt_d  = beat_cnt_q;
    gap_d       = gap_q;
    post_d      = post_q;
    crc_d       = crc_q;
    pkt_d       = {BUS_W{1'b0}};
    pkten_d     = 1'b0;
    clk_hs_en_d = clk_hs_en_q;
    d_hs_en_d   = d_hs_en_q;
    underrun_d  = underrun_q;
    len_err_d   = 1'b0;

    // The post counter runs in IDLE; expiry releases the HS clock.
    if (post_q != 8'd0) begin
      post_d = post_q - 8'd1;
      if (post_q == 8'd1) begin
        clk_hs_en_d = 1'b0;
      end else begin
        clk_hs_en_d = clk_hs_en_q;
      end
    end else begin
      post_d = 8'd0;
    end

    case (state_q)
      ST_IDLE: begin
        if (gap_q != 4'd0) begin
          gap_d = gap_q - 4'd1;
        end else begin
          gap_d = 4'd0;
        end
        if (req_valid_i && req_ready_s) begin
          if (!req_short_s && (req_wc_i[1:0] != 2'b00)) begin
            len_err_d = 1'b1;
          end else begin
            vc_d        = req_vc_i;
            dt_d        = req_dt_i;
            wc_d        = req_wc_i;
            crc_d       = CRC_INIT;
            d_hs_en_d   = 1'b1;
            clk_hs_en_d = 1'b1;
            post_d      = 8'd0;
            state_d     = ST_HS_REQ;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HS_REQ: begin
        if (d_hs_rdy_i) begin
          pkt_d   = BUS_W'(csi2_header(vc_q, dt_q, wc_q));
          pkten_d = 1'b1;
          if (pkt_short_s) begin
            state_d = ST_EXIT;
          end else if (wc_q == 16'd0) begin
            state_d = ST_CRC;
          end else begin
            beat_cnt_d = wc_q[15:2];
            state_d    = ST_PAYLD;
          end
        end else begin
          state_d = ST_HS_REQ;
        end
      end
      ST_PAYLD: begin
        pkt_d      = beat_s;
        pkten_d    = 1'b1;
        crc_d      = crc_next_s;
        beat_cnt_d = beat_cnt_q - 14'd1;
        if (!pld_valid_i) begin
          underrun_d = 1'b1;
        end else begin
          underrun_d = underrun_q;
        end
        if (beat_cnt_q == 14'd1) begin
          state_d = ST_CRC;
        end else begin
          state_d = ST_PAYLD;
        end
      end
      ST_CRC: begin
        pkt_d   = BUS_W'({16'h0000, crc_q[15:8], crc_q[7:0]});
        pkten_d = 1'b1;
        state_d = ST_EXIT;
      end
      ST_EXIT: begin
        d_hs_en_d = 1'b0;
        gap_d     = EXIT_GAP_L;
        if (CLK_CONTINUOUS) begin
          post_d = 8'd0;
        end else begin
          post_d = CLK_POST_L;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge core_clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      vc_q        <= 2'd0;
      dt_q        <= 6'd0;
      wc_q        <= 16'd0;
      beat_cnt_q  <= 14'd0;
      gap_q       <= 4'd0;
      post_q      <= 8'd0;
      crc_q       <= CRC_INIT;
      pkt_q       <= {BUS_W{1'b0}};
      pkten_q     <= 1'b0;
      clk_hs_en_q <= 1'b0;
      d_hs_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      vc_q        <= vc_d;
      dt_q        <= dt_d;
      wc_q        <= wc_d;
      beat_cnt_q  <= beat_cnt_d;
      gap_q       <= gap_d;
      post_q      <= post_d;
      crc_q       <= crc_d;
      pkt_q       <= pkt_d;
      pkten_q     <= pkten_d;
      clk_hs_en_q <= clk_hs_en_d;
      d_hs_en_q   <= d_hs_en_d;
      busy_q      <= busy_d;
      underrun_q  <= underrun_d;
      len_err_q   <= len_err_d;
    end
  end

  assign dphy_pkten_o = pkten_q;
  assign dphy_pkt_o   = pkt_q;
  assign clk_hs_en_o  = clk_hs_en_q;
  assign d_hs_en_o    = d_hs_en_q;
  assign busy_o       = busy_q;
  assign underrun_o   = underrun_q;
  assign len_err_o    = len_err_q;

endmodule

// File: tb/tb_csi2_tx_pkt_formatter.sv
// Directed bench for csi2_tx_pkt_formatter: short/long/empty packets, length error,
// payload underrun, back-to-back clock reuse and mid-packet reset.
module tb_csi2_tx_pkt_formatter;

  localparam int EXIT_GAP = 4;
  localparam int CLK_POST = 8;

  logic        core_clk = 1'b0;
  logic        reset;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_vc_i;
  logic [5:0]  req_dt_i;
  logic [15:0] req_wc_i;
  logic [31:0] pld_data_i;
  logic        pld_valid_i;
  logic        pld_ready_o;
  logic        dphy_pkten_o;
  logic [31:0] dphy_pkt_o;
  logic        clk_hs_en_o;
  logic        d_hs_en_o;
  logic        d_hs_rdy_i;
  logic        busy_o;
  logic        underrun_o;
  logic        len_err_o;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] cap[$];
  logic [31:0] pld_src[$];
  logic [31:0] exp_pld[$];
  int          gap_idx;
  int          clk_drops;
  logic        prev_clk;

  csi2_tx_pkt_formatter #(
    .DATA_WIDTH     (8),
    .CLK_CONTINUOUS (1'b0),
    .EXIT_GAP       (EXIT_GAP),
    .CLK_POST       (CLK_POST)
  ) dut (
    .core_clk     (core_clk),
    .reset        (reset),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_vc_i     (req_vc_i),
    .req_dt_i     (req_dt_i),
    .req_wc_i     (req_wc_i),
    .pld_data_i   (pld_data_i),
    .pld_valid_i  (pld_valid_i),
    .pld_ready_o  (pld_ready_o),
    .dphy_pkten_o (dphy_pkten_o),
    .dphy_pkt_o   (dphy_pkt_o),
    .clk_hs_en_o  (clk_hs_en_o),
    .d_hs_en_o    (d_hs_en_o),
    .d_hs_rdy_i   (d_hs_rdy_i),
    .busy_o       (busy_o),
    .underrun_o   (underrun_o),
    .len_err_o    (len_err_o)
  );

  always #5 core_clk = ~core_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge core_clk);
    if (prev_clk && !clk_hs_en_o) clk_drops++;
    prev_clk = clk_hs_en_o;
  endtask

  // Header ECC written out from the CSI-2 parity equations.
  function automatic logic [5:0] ecc_ref(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return p;
  endfunction

  function automatic logic [31:0] hdr_ref(input logic [1:0] vc, input logic [5:0] dt,
                                          input logic [15:0] wc);
    logic [23:0] d;
    d = {wc[15:8], wc[7:0], vc, dt};
    return {2'b00, ecc_ref(d), d};
  endfunction

  // Byte-wise reflected CRC-16 over exp_pld, byte0 first.
  function automatic logic [15:0] crc_ref();
    logic [15:0] c;
    logic [7:0]  b;
    c = 16'hFFFF;
    foreach (exp_pld[k]) begin
      for (int j = 0; j < 4; j++) begin
        b = exp_pld[k][8*j +: 8];
        c = c ^ {8'h00, b};
        for (int s = 0; s < 8; s++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
      end
    end
    return c;
  endfunction

  function automatic logic [31:0] cap_at(input int i);
    if (i < cap.size()) return cap[i];
    return 32'hxxxxxxxx;
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready_o && n < 200) begin
      tick();
      n++;
    end
    if (!req_ready_o) chk("req_ready_timeout", 32'(req_ready_o), 32'd1);
  endtask

  task automatic issue_req(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc);
    wait_ready();
    req_valid_i = 1'b1;
    req_vc_i    = vc;
    req_dt_i    = dt;
    req_wc_i    = wc;
    tick();
    req_valid_i = 1'b0;
  endtask

  // Sends one request and captures beats until d_hs_en_o falls.
  task automatic run_pkt(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                         input int rdy_delay, input int drop_rdy_after);
    int en_cycles;
    int idx;
    int n;
    bit done;
    en_cycles = 0; idx = 0; n = 0; done = 1'b0;
    cap.delete();
    issue_req(vc, dt, wc);
    while (!done && n < 2000) begin
      if (dphy_pkten_o) cap.push_back(dphy_pkt_o);
      if (d_hs_en_o) en_cycles++;
      else if (en_cycles > 0) done = 1'b1;
      if (en_cycles > rdy_delay) d_hs_rdy_i = 1'b1;
      if (drop_rdy_after >= 0 && idx >= drop_rdy_after) d_hs_rdy_i = 1'b0;
      if (pld_ready_o) begin
        pld_valid_i = (idx != gap_idx);
        pld_data_i  = (idx < pld_src.size()) ? pld_src[idx] : 32'hDEADBEEF;
        idx++;
      end else begin
        pld_valid_i = 1'b0;
        pld_data_i  = 32'hDEADBEEF;
      end
      if (!done) begin
        tick();
        n++;
      end
    end
    d_hs_rdy_i  = 1'b0;
    pld_valid_i = 1'b0;
    chk("pkt_completed", 32'(done), 32'd1);
  endtask

  initial begin
    int n;
    int errs;
    bit dlow;
    bit seen_en;
    bit seen_busy;
    bit seen_pkten;

    reset = 1'b1; req_valid_i = 1'b0; req_vc_i = 2'd0; req_dt_i = 6'd0; req_wc_i = 16'd0;
    pld_data_i = 32'd0; pld_valid_i = 1'b0; d_hs_rdy_i = 1'b0;
    gap_idx = -1; clk_drops = 0; prev_clk = 1'b0;
    repeat (3) tick();
    chk("rst_pkten", 32'(dphy_pkten_o), 32'd0);
    chk("rst_pkt", dphy_pkt_o, 32'd0);
    chk("rst_clk_hs", 32'(clk_hs_en_o), 32'd0);
    chk("rst_d_hs", 32'(d_hs_en_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_flags", {30'd0, underrun_o, len_err_o}, 32'd0);
    chk("rst_readies", {30'd0, req_ready_o, pld_ready_o}, 32'd0);
    reset = 1'b0;
    tick();
    chk("req_ready_after_reset", 32'(req_ready_o), 32'd1);

    // Short packet, ready 3 cycles late.
    pld_src.delete();
    run_pkt(2'd0, 6'h00, 16'h0001, 3, -1);
    chk("short_beats", 32'(cap.size()), 32'd1);
    chk("short_hdr_hand", cap_at(0), 32'h1A000100);
    chk("short_hdr_model", cap_at(0), hdr_ref(2'd0, 6'h00, 16'h0001));
    chk("short_clk_held", 32'(clk_hs_en_o), 32'd1);
    n = 0; dlow = 1'b1;
    while (!req_ready_o && n < 50) begin
      if (d_hs_en_o) dlow = 1'b0;
      tick();
      n++;
    end
    chk("exit_gap_cycles", 32'(n), 32'(EXIT_GAP));
    chk("exit_gap_d_low", 32'(dlow), 32'd1);

    // Long packet, incrementing bytes; ready drops mid-payload.
    pld_src.delete();
    for (int k = 0; k < 124; k++)
      pld_src.push_back({8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
    exp_pld = pld_src;
    run_pkt(2'd0, 6'h37, 16'h01F0, 1, 10);
    chk("long_beats", 32'(cap.size()), 32'd126);
    chk("long_hdr", cap_at(0), 32'h3F01F037);
    errs = 0;
    for (int k = 0; k < 124; k++) if (cap_at(k+1) !== pld_src[k]) errs++;
    chk("long_payload_errs", 32'(errs), 32'd0);
    chk("long_crc", cap_at(125), {16'h0000, crc_ref()});
    chk("long_no_underrun", 32'(underrun_o), 32'd0);

    // Long packet with zero word count.
    pld_src.delete();
    run_pkt(2'd0, 6'h2A, 16'h0000, 0, -1);
    chk("wc0_beats", 32'(cap.size()), 32'd2);
    chk("wc0_hdr", cap_at(0), 32'h1000002A);
    chk("wc0_crc", cap_at(1), 32'h0000FFFF);

    // Misaligned long word count is rejected.
    issue_req(2'd0, 6'h2A, 16'h0006);
    chk("len_err_pulse", 32'(len_err_o), 32'd1);
    chk("len_err_busy", 32'(busy_o), 32'd0);
    tick();
    chk("len_err_single", 32'(len_err_o), 32'd0);
    seen_en = 1'b0; seen_busy = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (d_hs_en_o) seen_en = 1'b1;
      if (busy_o) seen_busy = 1'b1;
      tick();
    end
    chk("len_err_no_d_hs", 32'(seen_en), 32'd0);
    chk("len_err_no_busy", 32'(seen_busy), 32'd0);

    // Payload gap on beat 2 of 4.
    pld_src.delete();
    pld_src.push_back(32'hA3A2A1A0); pld_src.push_back(32'hB3B2B1B0);
    pld_src.push_back(32'hC3C2C1C0); pld_src.push_back(32'hD3D2D1D0);
    exp_pld = pld_src;
    exp_pld[1] = 32'h00000000;
    gap_idx = 1;
    run_pkt(2'd1, 6'h2B, 16'h0010, 2, -1);
    gap_idx = -1;
    chk("gap_beats", 32'(cap.size()), 32'd6);
    chk("gap_hdr", cap_at(0), hdr_ref(2'd1, 6'h2B, 16'h0010));
    chk("gap_beat0", cap_at(1), 32'hA3A2A1A0);
    chk("gap_zero_beat", cap_at(2), 32'h00000000);
    chk("gap_beat3", cap_at(4), 32'hD3D2D1D0);
    chk("gap_crc", cap_at(5), {16'h0000, crc_ref()});
    chk("gap_underrun", 32'(underrun_o), 32'd1);

    // Back-to-back packets reuse the HS clock inside the post window.
    repeat (CLK_POST + EXIT_GAP + 5) tick();
    chk("clk_released_idle", 32'(clk_hs_en_o), 32'd0);
    clk_drops = 0;
    pld_src.delete();
    run_pkt(2'd2, 6'h01, 16'h1234, 0, -1);
    chk("b2b_first_hdr", cap_at(0), hdr_ref(2'd2, 6'h01, 16'h1234));
    pld_src.push_back(32'h87654321);
    exp_pld = pld_src;
    run_pkt(2'd0, 6'h2A, 16'h0004, 0, -1);
    chk("b2b_clk_no_drop", 32'(clk_drops), 32'd0);
    chk("b2b_second_beats", 32'(cap.size()), 32'd3);
    chk("b2b_second_crc", cap_at(2), {16'h0000, crc_ref()});
    n = 0;
    while (clk_hs_en_o && n < 100) begin
      tick();
      n++;
    end
    chk("clk_post_cycles", 32'(n), 32'(CLK_POST));
    chk("clk_drop_once", 32'(clk_drops), 32'd1);

    // Reset in the middle of the payload.
    pld_src.delete();
    for (int k = 0; k < 16; k++) pld_src.push_back(32'h01010101 * 32'(k + 1));
    issue_req(2'd0, 6'h2A, 16'h0040);
    d_hs_rdy_i = 1'b1;
    n = 0;
    while (!pld_ready_o && n < 50) begin
      tick();
      n++;
    end
    chk("midrst_in_payload", 32'(pld_ready_o), 32'd1);
    for (int k = 0; k < 3; k++) begin
      pld_valid_i = 1'b1;
      pld_data_i  = pld_src[k];
      tick();
    end
    reset = 1'b1;
    pld_valid_i = 1'b0;
    d_hs_rdy_i = 1'b0;
    tick();
    chk("midrst_pkten", 32'(dphy_pkten_o), 32'd0);
    chk("midrst_pkt", dphy_pkt_o, 32'd0);
    chk("midrst_hs", {30'd0, clk_hs_en_o, d_hs_en_o}, 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_flags", {30'd0, underrun_o, len_err_o}, 32'd0);
    chk("midrst_readies", {30'd0, req_ready_o, pld_ready_o}, 32'd0);
    reset = 1'b0;
    seen_pkten = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (dphy_pkten_o) seen_pkten = 1'b1;
    end
    chk("midrst_no_footer", 32'(seen_pkten), 32'd0);
    chk("midrst_ready_back", 32'(req_ready_o), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
